// File: rtl/array_stream_writer.sv
// Serial-to-array writer: fills a ROWS x COLS array row-major from a valid/ready stream
// and hands the complete frame to a downstream consumer with a valid/ready handoff.
module array_stream_writer #(
    parameter int unsigned ROWS  = 2,
    parameter int unsigned COLS  = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [WIDTH-1:0]                   DIN,
    input  logic                               DIN_VALID,
    input  logic                               DIN_LAST,
    output logic                               DIN_READY,
    output logic [WIDTH-1:0]                   ARR [ROWS][COLS],
    output logic                               ARR_VALID,
    input  logic                               ARR_READY,
    output logic [$clog2(ROWS*COLS+1)-1:0]     COUNT,
    output logic [15:0]                        FRAMES
);

    localparam int unsigned N   = ROWS * COLS;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned FW  = 16;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  row_q;
    logic [CLW-1:0] col_q;
    logic [CW-1:0]  count_q;
    logic [FW-1:0]  frames_q;
    logic           arr_valid_q;
    logic           wr_en;
    logic           wr_zero;
    logic           handoff;
    logic           last_idx;

    assign last_idx = (row_q == RW'(ROWS - 1)) && (col_q == CLW'(COLS - 1));

    // Ready is a pure function of state, held low while reset is asserted.
    assign DIN_READY = (state_q == S_FILL) && !RST;
    assign ARR_VALID = arr_valid_q;
    assign COUNT     = count_q;
    assign FRAMES    = frames_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_zero = 1'b0;
        handoff = 1'b0;
        case (state_q)
            S_FILL: begin
                if (DIN_VALID) begin
                    wr_en = 1'b1;
                    if (last_idx) begin
                        state_d = S_HOLD;
                    end else if (DIN_LAST) begin
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                wr_en   = 1'b1;
                wr_zero = 1'b1;
                if (last_idx) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ARR_READY) begin
                    handoff = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Storage, write pointer and frame bookkeeping; ARR is retained across handoff.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                for (int c = 0; c < int'(COLS); c++) begin
                    ARR[r][c] <= '0;
                end
            end
            row_q       <= '0;
            col_q       <= '0;
            count_q     <= '0;
            frames_q    <= '0;
            arr_valid_q <= 1'b0;
        end else begin
            arr_valid_q <= (state_d == S_HOLD);
            if (wr_en) begin
                ARR[row_q][col_q] <= wr_zero ? '0 : DIN;
                count_q           <= count_q + CW'(1);
                if (last_idx) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (col_q == CLW'(COLS - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CLW'(1);
                end
            end
            if (handoff) begin
                row_q    <= '0;
                col_q    <= '0;
                count_q  <= '0;
                frames_q <= frames_q + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_array_stream_writer.sv
// Directed, table-driven bench for array_stream_writer at ROWS=2, COLS=2, WIDTH=16.
module tb_array_stream_writer;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_last;
    logic        din_ready;
    logic [15:0] arr [2][2];
    logic        arr_valid;
    logic        arr_ready;
    logic [2:0]  count;
    logic [15:0] frames;

    int errors = 0;
    int checks = 0;

    array_stream_writer #(.ROWS(2), .COLS(2), .WIDTH(16)) dut (
        .CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(din_valid), .DIN_LAST(din_last),
        .DIN_READY(din_ready), .ARR(arr), .ARR_VALID(arr_valid), .ARR_READY(arr_ready),
        .COUNT(count), .FRAMES(frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic        v;
        logic        l;
        logic        ar;
        logic        e_rdy;
        logic        e_vld;
        logic [2:0]  e_cnt;
        logic [15:0] e_frm;
        logic [63:0] e_arr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic vld,
                           input logic [2:0] cnt, input logic [15:0] frm, input logic [63:0] ea);
        chk({tag, " din_ready"}, 32'(din_ready), 32'(rdy));
        chk({tag, " arr_valid"}, 32'(arr_valid), 32'(vld));
        chk({tag, " count"},     32'(count),     32'(cnt));
        chk({tag, " frames"},    32'(frames),    32'(frm));
        chk({tag, " arr00"}, 32'(arr[0][0]), 32'(ea[63:48]));
        chk({tag, " arr01"}, 32'(arr[0][1]), 32'(ea[47:32]));
        chk({tag, " arr10"}, 32'(arr[1][0]), 32'(ea[31:16]));
        chk({tag, " arr11"}, 32'(arr[1][1]), 32'(ea[15:0]));
    endtask

    task automatic add(input logic [15:0] d, input logic v, input logic l, input logic ar,
                       input logic rdy, input logic vld, input logic [2:0] cnt,
                       input logic [15:0] frm, input logic [63:0] ea);
        vec_t t;
        t.din = d; t.v = v; t.l = l; t.ar = ar;
        t.e_rdy = rdy; t.e_vld = vld; t.e_cnt = cnt; t.e_frm = frm; t.e_arr = ea;
        vq.push_back(t);
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step(input logic [15:0] d, input logic v, input logic l, input logic ar);
        din = d; din_valid = v; din_last = l; arr_ready = ar;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0; arr_ready = 1'b0;

        //   din      v  l  ar   rdy vld cnt frm  {a00,a01,a10,a11}
        add(16'h1111, 1, 0, 0,   1,  0,  1,  0,  64'h1111_0000_0000_0000);
        add(16'h2222, 1, 0, 0,   1,  0,  2,  0,  64'h1111_2222_0000_0000);
        add(16'h3333, 1, 0, 0,   1,  0,  3,  0,  64'h1111_2222_3333_0000);
        add(16'h4444, 1, 0, 0,   0,  1,  4,  0,  64'h1111_2222_3333_4444);
        add(16'hBEEF, 1, 0, 0,   0,  1,  4,  0,  64'h1111_2222_3333_4444);
        add(16'hBEEF, 1, 0, 1,   1,  0,  0,  1,  64'h1111_2222_3333_4444);
        add(16'hAAAA, 1, 1, 0,   0,  0,  1,  1,  64'hAAAA_2222_3333_4444);
        add(16'h5555, 1, 0, 0,   0,  0,  2,  1,  64'hAAAA_0000_3333_4444);
        add(16'h5555, 1, 0, 1,   0,  0,  3,  1,  64'hAAAA_0000_0000_4444);
        add(16'h0000, 0, 0, 0,   0,  1,  4,  1,  64'hAAAA_0000_0000_0000);
        add(16'h0000, 0, 0, 1,   1,  0,  0,  2,  64'hAAAA_0000_0000_0000);
        add(16'h0001, 1, 0, 0,   1,  0,  1,  2,  64'h0001_0000_0000_0000);
        add(16'h0002, 0, 0, 0,   1,  0,  1,  2,  64'h0001_0000_0000_0000);
        add(16'h0003, 1, 0, 0,   1,  0,  2,  2,  64'h0001_0003_0000_0000);
        add(16'h0004, 0, 0, 0,   1,  0,  2,  2,  64'h0001_0003_0000_0000);
        add(16'h0005, 1, 0, 0,   1,  0,  3,  2,  64'h0001_0003_0005_0000);
        add(16'h0006, 1, 0, 0,   0,  1,  4,  2,  64'h0001_0003_0005_0006);
        add(16'h0007, 1, 1, 1,   1,  0,  0,  3,  64'h0001_0003_0005_0006);
        add(16'h0010, 1, 0, 0,   1,  0,  1,  3,  64'h0010_0003_0005_0006);
        add(16'h0020, 1, 0, 0,   1,  0,  2,  3,  64'h0010_0020_0005_0006);
        add(16'h0030, 1, 0, 0,   1,  0,  3,  3,  64'h0010_0020_0030_0006);
        add(16'h0040, 1, 1, 0,   0,  1,  4,  3,  64'h0010_0020_0030_0040);
        add(16'h0000, 0, 0, 1,   1,  0,  0,  4,  64'h0010_0020_0030_0040);

        repeat (2) @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 3'd0, 16'd0, 64'h0);
        rst = 1'b0;
        #1;
        chk("ready after reset release", 32'(din_ready), 32'd1);

        foreach (vq[i]) begin
            step(vq[i].din, vq[i].v, vq[i].l, vq[i].ar);
            chk_all($sformatf("vec%0d", i), vq[i].e_rdy, vq[i].e_vld, vq[i].e_cnt,
                    vq[i].e_frm, vq[i].e_arr);
        end

        // Long stall in HOLD: ARR must not move while a consumer is not ready.
        step(16'hC001, 1, 0, 0);
        step(16'hC002, 1, 0, 0);
        step(16'hC003, 1, 0, 0);
        step(16'hC004, 1, 0, 0);
        chk_all("hold entry", 1'b0, 1'b1, 3'd4, 16'd4, 64'hC001_C002_C003_C004);
        for (int k = 0; k < 10; k++) begin
            step(16'hBEEF, 1, 0, 0);
            chk_all($sformatf("stall%0d", k), 1'b0, 1'b1, 3'd4, 16'd4, 64'hC001_C002_C003_C004);
        end
        step(16'hBEEF, 1, 0, 1);
        chk_all("stall release", 1'b1, 1'b0, 3'd0, 16'd5, 64'hC001_C002_C003_C004);
        step(16'hD00D, 1, 0, 0);
        chk_all("first after release", 1'b1, 1'b0, 3'd1, 16'd5, 64'hD00D_C002_C003_C004);

        // Reset mid-frame clears storage immediately and discards the partial frame.
        step(16'hD00E, 1, 0, 0);
        chk("pre-reset count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk_all("async reset", 1'b0, 1'b0, 3'd0, 16'd0, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step(16'h7777, 1, 0, 0);
        chk_all("post-reset beat", 1'b1, 1'b0, 3'd1, 16'd0, 64'h7777_0000_0000_0000);

        // Frame counter wrap from 0xFFFF to 0 via a preset of the counter.
        force dut.frames_q = 16'hFFFF;
        #1;
        release dut.frames_q;
        chk("frames preset", 32'(frames), 32'hFFFF);
        step(16'h0101, 1, 1, 0);
        step(16'h0000, 0, 0, 0);
        step(16'h0000, 0, 0, 0);
        chk_all("pad into hold", 1'b0, 1'b1, 3'd4, 16'hFFFF, 64'h7777_0101_0000_0000);
        step(16'h0000, 0, 0, 1);
        chk_all("frames wrap", 1'b1, 1'b0, 3'd0, 16'h0000, 64'h7777_0101_0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
